simt_mem_seq: RTL and testbench
===============================

# simt_mem_seq

Parametrised per-lane memory sequencer for the SIMT datapath. It replaces lane-0-only load/store handling so that every active lane of a warp can issue its own load or store. A warp-wide request is latched in one cycle and serialised into single-word accesses, in ascending lane order, over a ready-handshake data-memory port. Load results are returned as a flat per-lane vector for register-file writeback.

## Interface
Parameters:
- LANES, 16, lane count per warp (1..32)
- DATA_W, 16, data word width
- ADDR_W, 16, word address width

Ports (clock and reset first; reset is synchronous and active-high):
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request strobe; sampled only in IDLE
- is_load  in  1  1 = load, 0 = store; latched with start
- active_mask  in  LANES  lane i participates when bit i = 1; latched with start
- addr_in  in  LANES*ADDR_W  lane i address in bits [i*ADDR_W +: ADDR_W]; latched
- wdata_in  in  LANES*DATA_W  lane i store data; latched
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle completion pulse
- rdata_out  out  LANES*DATA_W  per-lane load results
- mem_req  out  1  access request
- mem_we  out  1  1 = write access
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  DATA_W  write data
- mem_ready  in  1  memory accepts or completes the current access this cycle
- mem_rdata  in  DATA_W  read data, valid in the cycle mem_ready = 1 with mem_we = 0

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: when start = 1, latch is_load, active_mask, addr_in and wdata_in into internal copies, and clear rdata_out to 0 for all lanes.
  - If the latched mask is non-zero, go to RUN with the lane pointer set to the lowest set bit.
  - If the mask is zero, go directly to DONE. No memory access occurs.
- RUN: drive mem_req = 1, mem_we = !is_load, and the current lane's address and data.
  - On mem_ready = 1, the access completes. For a load, write mem_rdata into the current lane's slot of rdata_out.
  - After completion, advance to the next higher set bit of the mask. If no set bit remains, go to DONE.
  - Inactive lanes are skipped with zero cycle cost.
- DONE: done = 1 for exactly one cycle, then go to IDLE.
- start is ignored while busy = 1. Latched inputs are immune to input changes after acceptance.
- rdata_out holds its value from DONE until the next accepted start. Lanes that are inactive during a load read 0.
- Addresses pass through unmodified. There is no address arithmetic, and no wrap handling is required.
- The lane pointer has width clog2(LANES), with a minimum of 1 bit.

## Timing
- Reset values:
  - FSM = IDLE
  - busy = 0, done = 0
  - mem_req = 0, mem_we = 0
  - mem_addr = 0, mem_wdata = 0
  - rdata_out = 0
- start is accepted at edge T. mem_req = 1 from cycle T+1 for the first lane.
- Each access takes at least 1 cycle. With mem_ready tied to 1, K active lanes complete in K cycles, and done is asserted in cycle T+K+1.
- When the mask is zero, done is asserted in cycle T+1.
- mem_req, mem_addr, mem_we and mem_wdata stay stable while mem_req = 1 and mem_ready = 0.
- Back-to-back lanes: mem_req stays high and the address changes in the cycle after the completing edge. There are no idle bubbles between lanes.
- Reset asserted mid-RUN: at the next edge, all state returns to reset values and mem_req drops. A partially completed store sequence is not rolled back.
- start coinciding with done (the DONE cycle) is ignored. start is accepted from the following IDLE cycle.

## Configuration
- Macro: SIMT_MEM_SEQ_COALESCE_EN.
- Defined:
  - During a load, a lane whose latched address equals the address of the most recently serviced lane copies that lane's data without a memory access.
  - The copy costs 0 cycles and counts as a skip.
  - Stores are never coalesced.
- Undefined: every active lane issues its own access, and the comparator logic is absent.

## Test plan
- Reset and idle: assert reset for 2 cycles. All outputs read 0. Holding start = 0 keeps busy = 0 indefinitely.
- Full-warp store:
  - Stimulus: mask = 0xFFFF, addr lane i = 0x0100 + i, wdata lane i = 0xA000 + i, mem_ready = 1.
  - Required response: 16 consecutive write accesses, addresses 0x0100..0x010F in order, done in cycle T+17.
- Sparse load with stalls:
  - Stimulus: mask = 0x8005, memory returns addr XOR 0x5555, mem_ready low for 2 cycles per access.
  - Required response: only lanes 0, 2 and 15 are accessed, each held 3 cycles with stable outputs. Those lanes hold their correct results; all other lanes read 0.
- Zero mask: start with mask = 0x0000. done is asserted in cycle T+1 and mem_req never rises.
- Mid-operation reset: reset asserted while the lane-3 access is pending. The next cycle shows mem_req = 0, busy = 0 and rdata_out = 0. A new start afterwards runs normally.
- Coalescing (macro defined): load with mask = 0x000F, all lanes at address 0x0040. Exactly 1 memory access occurs, all 4 lanes receive the same data, and done is asserted in cycle T+2.

Source files
------------

// File: rtl/simt_mem_seq.sv
// simt_mem_seq: per-lane SIMT load/store sequencer.
// A warp request is latched in IDLE, then each active lane is serialised
// (ascending lane order) onto a single-word ready-handshake memory port.
// Optional macro SIMT_MEM_SEQ_COALESCE_EN: during loads, a lane whose address
// matches the most recently serviced lane copies that data without an access.
module simt_mem_seq #(
    parameter int LANES  = 16,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     is_load,
    input  logic [LANES-1:0]         active_mask,
    input  logic [LANES*ADDR_W-1:0]  addr_in,
    input  logic [LANES*DATA_W-1:0]  wdata_in,
    output logic                     busy,
    output logic                     done,
    output logic [LANES*DATA_W-1:0]  rdata_out,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_ready,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                    state;
    logic                          ld;
    logic [LANES-1:0]              mask_q;
    logic [LANES-1:0][ADDR_W-1:0]  addr_q;
    logic [LANES-1:0][DATA_W-1:0]  wdata_q;
    logic [LANES-1:0][DATA_W-1:0]  rdata_q;
    logic [PW-1:0]                 ptr;

    logic [PW-1:0]                 first;
    logic [PW-1:0]                 nxt;
    logic                          found;
    logic                          stop;
`ifdef SIMT_MEM_SEQ_COALESCE_EN
    logic [LANES-1:0]              cmask;
`endif

    // Lowest set bit of the incoming mask: the first lane to service.
    always_comb begin
        first = '0;
        for (int i = LANES - 1; i >= 0; i--)
            if (active_mask[i]) first = PW'(i);
    end

    // Next lane needing a real access above the current one; with coalescing,
    // same-address load lanes in between are marked for a free copy instead.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        stop  = 1'b0;
`ifdef SIMT_MEM_SEQ_COALESCE_EN
        cmask = '0;
`endif
        for (int i = 0; i < LANES; i++) begin
            if (i > int'(ptr) && mask_q[i] && !stop) begin
`ifdef SIMT_MEM_SEQ_COALESCE_EN
                if (ld && addr_q[i] == addr_q[ptr]) begin
                    cmask[i] = 1'b1;
                end else begin
                    nxt   = PW'(i);
                    found = 1'b1;
                    stop  = 1'b1;
                end
`else
                nxt   = PW'(i);
                found = 1'b1;
                stop  = 1'b1;
`endif
            end
        end
    end

    // Sequencer FSM, request latch and load-result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            ld      <= 1'b0;
            mask_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ptr     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ld      <= is_load;
                        mask_q  <= active_mask;
                        addr_q  <= addr_in;
                        wdata_q <= wdata_in;
                        rdata_q <= '0;
                        ptr     <= first;
                        state   <= (|active_mask) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (mem_ready) begin
                        if (ld) begin
                            rdata_q[ptr] <= mem_rdata;
`ifdef SIMT_MEM_SEQ_COALESCE_EN
                            for (int i = 0; i < LANES; i++)
                                if (cmask[i]) rdata_q[i] <= mem_rdata;
`endif
                        end
                        if (found) ptr   <= nxt;
                        else       state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Memory port is driven only in RUN so idle outputs read zero.
    assign mem_req   = (state == S_RUN);
    assign mem_we    = mem_req && !ld;
    assign mem_addr  = mem_req ? addr_q[ptr] : '0;
    assign mem_wdata = mem_we ? wdata_q[ptr] : '0;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign rdata_out = rdata_q;

endmodule

// File: tb/tb_simt_mem_seq.sv
// tb_simt_mem_seq: directed self-checking bench for simt_mem_seq
// (LANES=16, DATA_W=16, ADDR_W=16). Memory model returns addr ^ 0x5555,
// optionally stalling mem_ready for 2 cycles per access.
module tb_simt_mem_seq;

    logic         clk;
    logic         reset;
    logic         start;
    logic         is_load;
    logic [15:0]  active_mask;
    logic [255:0] addr_in;
    logic [255:0] wdata_in;
    logic         busy;
    logic         done;
    logic [255:0] rdata_out;
    logic         mem_req;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [15:0]  mem_wdata;
    logic         mem_ready;
    logic [15:0]  mem_rdata;

    logic         stall;
    logic [1:0]   wcnt;
    int           nvec;
    int           nerr;

    simt_mem_seq #(.LANES(16), .DATA_W(16), .ADDR_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load),
        .active_mask(active_mask), .addr_in(addr_in), .wdata_in(wdata_in),
        .busy(busy), .done(done), .rdata_out(rdata_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: ready after 2 wait cycles when stalling, else immediately.
    always @(posedge clk) begin
        if (mem_req && !mem_ready) wcnt <= wcnt + 2'd1;
        else                       wcnt <= 2'd0;
    end
    assign mem_ready = stall ? (wcnt == 2'd2) : 1'b1;
    assign mem_rdata = mem_addr ^ 16'h5555;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and let edge T accept it; returns in cycle T+1.
    task automatic issue(input logic ld, input logic [15:0] m);
        is_load     = ld;
        active_mask = m;
        start       = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        nvec++;
        if ({busy, done, mem_req, mem_we, mem_addr, mem_wdata} !== 36'h0) begin
            nerr++;
            $display("FAIL reset_ctrl: got busy=%b done=%b req=%b we=%b addr=%h wdata=%h, want all 0",
                     busy, done, mem_req, mem_we, mem_addr, mem_wdata);
        end
        nvec++;
        if (rdata_out !== 256'h0) begin
            nerr++;
            $display("FAIL reset_rdata: got %h want 0", rdata_out);
        end
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            nvec++;
            if (busy !== 1'b0 || mem_req !== 1'b0) begin
                nerr++;
                $display("FAIL idle_hold c%0d: got busy=%b req=%b want 0 0", c, busy, mem_req);
            end
        end
    endtask

    task automatic test_full_store();
        logic [15:0] ea, ed;
        for (int i = 0; i < 16; i++) begin
            addr_in[i*16 +: 16]  = 16'h0100 + 16'(i);
            wdata_in[i*16 +: 16] = 16'hA000 + 16'(i);
        end
        stall = 1'b0;
        issue(1'b0, 16'hFFFF);
        addr_in  = {16{16'hDEAD}};
        wdata_in = {16{16'hBEEF}};
        for (int k = 0; k < 16; k++) begin
            ea = 16'h0100 + 16'(k);
            ed = 16'hA000 + 16'(k);
            nvec++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, done} !== {1'b1, 1'b1, ea, ed, 1'b0}) begin
                nerr++;
                $display("FAIL store_lane%0d: got req=%b we=%b addr=%h wdata=%h done=%b want 1 1 %h %h 0",
                         k, mem_req, mem_we, mem_addr, mem_wdata, done, ea, ed);
            end
            tick();
        end
        nvec++;
        if (done !== 1'b1 || mem_req !== 1'b0) begin
            nerr++;
            $display("FAIL store_done_T+17: got done=%b req=%b want 1 0", done, mem_req);
        end
        tick();
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            nerr++;
            $display("FAIL store_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_full_load();
        logic [15:0] ev;
        for (int i = 0; i < 16; i++) addr_in[i*16 +: 16] = 16'h0300 + 16'(i);
        stall = 1'b0;
        issue(1'b1, 16'hFFFF);
        for (int k = 0; k < 16; k++) begin
            nvec++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0) begin
                nerr++;
                $display("FAIL load_req%0d: got req=%b we=%b want 1 0", k, mem_req, mem_we);
            end
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            ev = (16'h0300 + 16'(i)) ^ 16'h5555;
            nvec++;
            if (rdata_out[i*16 +: 16] !== ev || done !== 1'b1) begin
                nerr++;
                $display("FAIL load_rdata%0d: got %h done=%b want %h 1", i, rdata_out[i*16 +: 16], done, ev);
            end
        end
        tick();
    endtask

    task automatic test_sparse_load();
        int          lanes [3];
        logic [15:0] ea, ev;
        lanes = '{0, 2, 15};
        for (int i = 0; i < 16; i++) addr_in[i*16 +: 16] = 16'h0200 + 16'(3 * i);
        stall = 1'b1;
        issue(1'b1, 16'h8005);
        for (int n = 0; n < 3; n++) begin
            ea = 16'h0200 + 16'(3 * lanes[n]);
            for (int c = 0; c < 3; c++) begin
                nvec++;
                if ({mem_req, mem_we, mem_addr, done} !== {1'b1, 1'b0, ea, 1'b0}) begin
                    nerr++;
                    $display("FAIL sparse_lane%0d_c%0d: got req=%b we=%b addr=%h done=%b want 1 0 %h 0",
                             lanes[n], c, mem_req, mem_we, mem_addr, done, ea);
                end
                tick();
            end
        end
        nvec++;
        if (done !== 1'b1) begin
            nerr++;
            $display("FAIL sparse_done: got %b want 1", done);
        end
        for (int i = 0; i < 16; i++) begin
            ev = (i == 0 || i == 2 || i == 15) ? ((16'h0200 + 16'(3 * i)) ^ 16'h5555) : 16'h0000;
            nvec++;
            if (rdata_out[i*16 +: 16] !== ev) begin
                nerr++;
                $display("FAIL sparse_rdata%0d: got %h want %h", i, rdata_out[i*16 +: 16], ev);
            end
        end
        stall = 1'b0;
        tick();
    endtask

    task automatic test_zero_mask();
        issue(1'b1, 16'h0000);
        nvec++;
        if ({done, busy, mem_req} !== 3'b110 || rdata_out !== 256'h0) begin
            nerr++;
            $display("FAIL zero_T+1: got done=%b busy=%b req=%b rdata_nz=%b want 1 1 0 0",
                     done, busy, mem_req, |rdata_out);
        end
        tick();
        nvec++;
        if ({done, busy, mem_req} !== 3'b000) begin
            nerr++;
            $display("FAIL zero_T+2: got done=%b busy=%b req=%b want 0 0 0", done, busy, mem_req);
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] ev;
        for (int i = 0; i < 16; i++) addr_in[i*16 +: 16] = 16'h0400 + 16'(i);
        stall = 1'b1;
        issue(1'b1, 16'h00FF);
        for (int c = 0; c < 9; c++) tick();
        nvec++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0403) begin
            nerr++;
            $display("FAIL midrst_pending: got req=%b addr=%h want 1 0403", mem_req, mem_addr);
        end
        reset = 1'b1;
        tick();
        nvec++;
        if ({mem_req, busy, done} !== 3'b000 || rdata_out !== 256'h0) begin
            nerr++;
            $display("FAIL midrst_after: got req=%b busy=%b done=%b rdata_nz=%b want 0 0 0 0",
                     mem_req, busy, done, |rdata_out);
        end
        reset = 1'b0;
        stall = 1'b0;
        issue(1'b1, 16'h0002);
        nvec++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0401) begin
            nerr++;
            $display("FAIL midrst_restart: got req=%b addr=%h want 1 0401", mem_req, mem_addr);
        end
        tick();
        ev = 16'h0401 ^ 16'h5555;
        nvec++;
        if (done !== 1'b1 || rdata_out[31:16] !== ev || rdata_out[15:0] !== 16'h0) begin
            nerr++;
            $display("FAIL midrst_result: got done=%b l1=%h l0=%h want 1 %h 0000",
                     done, rdata_out[31:16], rdata_out[15:0], ev);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        stall       = 1'b0;
        is_load     = 1'b1;
        active_mask = 16'h0001;
        start       = 1'b1;
        tick();
        nvec++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0400) begin
            nerr++;
            $display("FAIL b2b_run: got req=%b addr=%h want 1 0400", mem_req, mem_addr);
        end
        tick();
        nvec++;
        if (done !== 1'b1 || mem_req !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_done: got done=%b req=%b want 1 0", done, mem_req);
        end
        tick();
        nvec++;
        if (busy !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_idle_gap: got busy=%b want 0", busy);
        end
        tick();
        nvec++;
        if (mem_req !== 1'b1 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL b2b_reaccept: got req=%b busy=%b want 1 1", mem_req, busy);
        end
        start = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_coalesce();
        int          acc, dcyc, want_acc, want_dcyc;
        logic [15:0] ev;
        acc  = 0;
        dcyc = 0;
`ifdef SIMT_MEM_SEQ_COALESCE_EN
        want_acc  = 1;
        want_dcyc = 2;
`else
        want_acc  = 4;
        want_dcyc = 5;
`endif
        for (int i = 0; i < 16; i++) addr_in[i*16 +: 16] = (i < 4) ? 16'h0040 : 16'h0700 + 16'(i);
        stall = 1'b0;
        issue(1'b1, 16'h000F);
        for (int c = 1; c <= 10; c++) begin
            if (done === 1'b1) begin
                dcyc = c;
                break;
            end
            if (mem_req === 1'b1 && mem_ready === 1'b1) acc++;
            tick();
        end
        nvec++;
        if (acc != want_acc || dcyc != want_dcyc) begin
            nerr++;
            $display("FAIL coalesce_timing: got accesses=%0d done_cycle=T+%0d want %0d T+%0d",
                     acc, dcyc, want_acc, want_dcyc);
        end
        for (int i = 0; i < 16; i++) begin
            ev = (i < 4) ? 16'h5515 : 16'h0000;
            nvec++;
            if (rdata_out[i*16 +: 16] !== ev) begin
                nerr++;
                $display("FAIL coalesce_rdata%0d: got %h want %h", i, rdata_out[i*16 +: 16], ev);
            end
        end
        tick();
    endtask

    initial begin
        nvec        = 0;
        nerr        = 0;
        reset       = 1'b1;
        start       = 1'b0;
        is_load     = 1'b0;
        active_mask = '0;
        addr_in     = '0;
        wdata_in    = '0;
        stall       = 1'b0;
        test_reset();
        test_full_store();
        test_full_load();
        test_sparse_load();
        test_zero_mask();
        test_mid_reset();
        test_back_to_back();
        test_coalesce();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
